// File: rtl/dcache_ctrl.sv
// dcache_ctrl: 32-line direct-mapped write-back/write-allocate data cache
// controller (32-byte lines, 32-bit words) with a single-beat line memory port.
// Ports: clk_i, rst_i (async, active-low)
//        cpu_req_i/cpu_we_i/cpu_addr_i/cpu_wdata_i -> cpu_rdata_o, stall_o
//        mem_req_o/mem_we_o/mem_addr_o/mem_wdata_o <- mem_rdata_i, mem_ack_i
module dcache_ctrl (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         cpu_req_i,
    input  logic         cpu_we_i,
    input  logic [31:0]  cpu_addr_i,
    input  logic [31:0]  cpu_wdata_i,
    output logic [31:0]  cpu_rdata_o,
    output logic         stall_o,
    output logic         mem_req_o,
    output logic         mem_we_o,
    output logic [31:0]  mem_addr_o,
    output logic [255:0] mem_wdata_o,
    input  logic [255:0] mem_rdata_i,
    input  logic         mem_ack_i
);

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        ALLOCATE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [31:0]  valid;
    logic [31:0]  dirty;
    logic [21:0]  tag_arr  [32];
    logic [255:0] data_arr [32];

    logic [21:0] req_tag;
    logic [4:0]  req_idx;
    logic [7:0]  req_off;
    logic        addr_unused;

    logic [21:0] miss_tag;
    logic [4:0]  miss_idx;

    logic hit;
    logic miss;
    logic store_hit;
    logic fill;

    assign req_tag     = cpu_addr_i[31:10];
    assign req_idx     = cpu_addr_i[9:5];
    assign req_off     = {cpu_addr_i[4:2], 5'b0};
    assign addr_unused = ^cpu_addr_i[1:0];

    assign hit = cpu_req_i & valid[req_idx] & (tag_arr[req_idx] == req_tag);
    assign miss = (state == IDLE) & cpu_req_i & ~hit;
    assign store_hit = (state == IDLE) & hit & cpu_we_i;
    assign fill = (state == ALLOCATE) & mem_ack_i;

    // Miss tag/index are captured when leaving IDLE so the transaction
    // completes even if the CPU withdraws its request mid-miss.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state    <= IDLE;
            miss_tag <= '0;
            miss_idx <= '0;
        end else begin
            state <= state_nxt;
            if (miss) begin
                miss_tag <= req_tag;
                miss_idx <= req_idx;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid <= '0;
            dirty <= '0;
        end else if (fill) begin
            valid[miss_idx] <= 1'b1;
            dirty[miss_idx] <= 1'b0;
        end else if (store_hit) begin
            dirty[req_idx] <= 1'b1;
        end
    end

    // Tag and data storage is deliberately left unreset; valid gates it.
    always_ff @(posedge clk_i) begin
        if (fill) begin
            tag_arr[miss_idx]  <= miss_tag;
            data_arr[miss_idx] <= mem_rdata_i;
        end else if (store_hit) begin
            data_arr[req_idx][req_off +: 32] <= cpu_wdata_i;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (miss) begin
                    if (valid[req_idx] & dirty[req_idx])
                        state_nxt = WRITEBACK;
                    else
                        state_nxt = ALLOCATE;
                end
            end
            WRITEBACK: begin
                if (mem_ack_i)
                    state_nxt = ALLOCATE;
            end
            ALLOCATE: begin
                if (mem_ack_i)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        stall_o     = 1'b1;
        unique case (state)
            IDLE: begin
                stall_o = cpu_req_i & ~hit;
            end
            WRITEBACK: begin
                mem_req_o   = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = {tag_arr[miss_idx], miss_idx, 5'b0};
                mem_wdata_o = data_arr[miss_idx];
            end
            ALLOCATE: begin
                mem_req_o  = 1'b1;
                mem_addr_o = {miss_tag, miss_idx, 5'b0};
            end
            default: begin
                stall_o = 1'b1;
            end
        endcase
    end

    assign cpu_rdata_o = hit ? data_arr[req_idx][req_off +: 32] : 32'h0;

endmodule

// File: doc/dcache_ctrl.md
DCACHE_CTRL -- requirements
Module: dcache_ctrl

Interface
REQ-001 The block SHALL have no parameters: 32 lines, 32-byte (256-bit) lines, 32-bit words, direct-mapped, write-back, write-allocate.
REQ-002 clk_i  in  1  single clock; all state updates on its rising edge.
REQ-003 rst_i  in  1  reset, asynchronous, active-low.
REQ-004 cpu_req_i  in  1  MEM-stage access request (MemRead or MemWrite).
REQ-005 cpu_we_i  in  1  1 = store, 0 = load.
REQ-006 cpu_addr_i  in  32  byte address: tag [31:10], index [9:5], word [4:2]; bits [1:0] are ignored.
REQ-007 cpu_wdata_i  in  32  store data.
REQ-008 cpu_rdata_o  out  32  load data.
REQ-009 stall_o  out  1  freezes PC and all pipeline registers while 1.
REQ-010 mem_req_o  out  1  memory transaction request.
REQ-011 mem_we_o  out  1  1 = line write-back, 0 = line fill.
REQ-012 mem_addr_o  out  32  line-aligned address; bits [4:0] are always 0.
REQ-013 mem_wdata_o  out  256  victim line data.
REQ-014 mem_rdata_i  in  256  fill data; sampled on the ack cycle.
REQ-015 mem_ack_i  in  1  one-cycle completion pulse from memory.

Function
REQ-016 Each line SHALL hold valid, dirty, a 22-bit tag and 256-bit data; word w occupies bits [32w+31:32w].
REQ-017 hit = cpu_req_i & valid[index] & (tag[index] == cpu_addr_i[31:10]), evaluated combinationally.
REQ-018 FSM states SHALL be IDLE, WRITEBACK and ALLOCATE, held in state registers; mem_req_o, mem_we_o and mem_addr_o SHALL be decoded from registered state only.
REQ-019 IDLE: stall_o = cpu_req_i & ~hit.
REQ-020 WRITEBACK and ALLOCATE: stall_o = 1.
REQ-021 cpu_rdata_o SHALL be the addressed word when hit = 1, and 32'h0 otherwise.
REQ-022 Load hit: data SHALL appear in the same cycle, with zero stall cycles.
REQ-023 Store hit: the word SHALL be written and dirty set at the next rising edge, with zero stall cycles.
REQ-024 Miss in IDLE: the next state SHALL be WRITEBACK if valid & dirty, otherwise ALLOCATE.
REQ-025 WRITEBACK: mem_req_o = 1, mem_we_o = 1, mem_addr_o = {victim tag, index, 5'b0}, mem_wdata_o = victim line; on mem_ack_i the next state SHALL be ALLOCATE.
REQ-026 ALLOCATE: mem_req_o = 1, mem_we_o = 0, mem_addr_o = {cpu tag, index, 5'b0}.
REQ-027 On mem_ack_i in ALLOCATE: capture mem_rdata_i, set valid = 1, dirty = 0, tag = cpu tag; the next state SHALL be IDLE.
REQ-028 After a fill, the held request SHALL hit in IDLE; a store miss SHALL complete as a store hit on that cycle (dirty = 1).
REQ-029 Miss penalty SHALL be (memory latency + 1) cycles per transaction.
REQ-030 mem_req_o SHALL stay 1 until the ack cycle and SHALL be 0 in the cycle after ack.
REQ-031 mem_ack_i in IDLE SHALL be ignored.
REQ-032 mem_wdata_o SHALL be 0 outside WRITEBACK.
REQ-033 The CPU SHALL hold its inputs stable while stall_o = 1.
REQ-034 If cpu_req_i drops mid-miss, the active transaction SHALL complete, the line SHALL be filled, and the FSM SHALL return to IDLE with no CPU write.
REQ-035 A write-back followed by a fill SHALL never be merged; they are two separate handshakes.

Reset
REQ-036 rst_i low SHALL immediately force IDLE and clear all valid and dirty bits; the data and tag arrays SHALL NOT be reset.
REQ-037 While rst_i is low: mem_req_o = 0, mem_we_o = 0, mem_addr_o = 0, mem_wdata_o = 0, cpu_rdata_o = 0, and stall_o = cpu_req_i (every access misses).
REQ-038 Reset during WRITEBACK or ALLOCATE SHALL abandon the transaction: mem_req_o falls asynchronously, and a late mem_ack_i SHALL be ignored.

Verification
REQ-039 Cold load: after reset, load 0x00000040 -> stall_o = 1, ALLOCATE, mem_addr_o = 0x40; ack with word 0 = 0x11111111 -> next cycle stall_o = 0, cpu_rdata_o = 0x11111111.
REQ-040 Dirty eviction: store hit 0x00000044 = 0xDEADBEEF (no stall), then load 0x00000444 -> WRITEBACK to 0x40 with mem_wdata_o[63:32] = 0xDEADBEEF, then ALLOCATE from 0x440.
REQ-041 Slow memory: ack delayed 10 cycles -> mem_req_o and stall_o held high for 11 cycles, then mem_req_o = 0.
REQ-042 Reset in ALLOCATE: assert rst_i -> mem_req_o = 0 with no clock edge; after release, the same load misses again.
REQ-043 Spurious ack in IDLE -> no state, array or output change.
REQ-044 cpu_req_i dropped during ALLOCATE -> the fill completes, IDLE is reached, and a later load to the same address hits with no stall.
